apb_cmd_master: RTL and testbench



---
 rtl/apb_cmd_pkg.sv | 25 ++
 rtl/apb_cmd_master_if.sv | 35 +++
 rtl/apb_cmd_fifo.sv | 49 ++++
 rtl/apb_cmd_master.sv | 140 ++++++++++++++
 tb/tb_apb_cmd_master.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_cmd_pkg.sv
// Shared types for the queued APB command master: bus FSM states and the
// command record held in the FIFO.
package apb_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam int CMD_ADDR_W = 8;
  localparam int CMD_DATA_W = 8;

  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } cmd_t;

  // Packed FIFO entry width: {write, addr, wdata}
  function automatic int cmd_width(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command/response and APB bus signals of apb_cmd_master; master is the
// block's own view, slave is the view of whatever sits around it.
interface apb_cmd_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic              apb_psel;
  logic              apb_penable;
  logic              apb_pwrite;
  logic [ADDR_W-1:0] apb_paddress;
  logic [DATA_W-1:0] apb_pwdata;
  logic [DATA_W-1:0] apb_prdata;
  logic              apb_pready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, apb_prdata, apb_pready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           apb_psel, apb_penable, apb_pwrite, apb_paddress, apb_pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, apb_prdata, apb_pready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           apb_psel, apb_penable, apb_pwrite, apb_paddress, apb_pwdata
  );
endinterface

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit so full and
// empty are distinguished without a separate count.
module apb_cmd_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             apb_pclk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok, pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    if (push_ok) mem_d[wr_ptr_q[AW-1:0]] = wdata;
  end

  always_ff @(posedge apb_pclk) begin
    mem_q <= mem_d;
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/apb_cmd_master.sv
// Queued APB master: pops commands from the FIFO, runs SETUP/ACCESS with
// wait-state and timeout handling, and returns one response per command.
module apb_cmd_master
  import apb_cmd_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input logic         apb_pclk,
  input logic         resetn,
  apb_cmd_master_if.master bus
);
  localparam int            CW      = cmd_width(ADDR_W, DATA_W);
  localparam int            TW      = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic              psel_q, psel_d, pen_q, pen_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [CW-1:0]     head;
  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  logic              pop, done, full, empty;

  apb_cmd_fifo #(.WIDTH(CW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .apb_pclk (apb_pclk),
    .resetn   (resetn),
    .push     (bus.cmd_valid),
    .wdata    ({bus.cmd_write, bus.cmd_addr, bus.cmd_wdata}),
    .pop      (pop),
    .rdata    (head),
    .full     (full),
    .empty    (empty)
  );

  assign {head_write, head_addr, head_wdata} = head;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    pen_d       = pen_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    pop         = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      IDLE: begin
        psel_d = 1'b0;
        pen_d  = 1'b0;
      end
      SETUP: begin
        pen_d   = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (bus.apb_pready) begin
          done        = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : bus.apb_prdata;
        end else if (cnt_q == TO_LAST) begin
          done        = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (done) begin
          state_d = IDLE;
          psel_d  = 1'b0;
          pen_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Completion chains straight into the next SETUP when work is queued
    if ((state_q == IDLE || done) && !empty) begin
      pop      = 1'b1;
      state_d  = SETUP;
      psel_d   = 1'b1;
      pen_d    = 1'b0;
      cnt_d    = '0;
      pwrite_d = head_write;
      paddr_d  = head_addr;
      pwdata_d = head_wdata;
    end
  end

  always_ff @(posedge apb_pclk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      pen_q       <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      pen_q       <= pen_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.cmd_ready    = !full;
  assign bus.busy         = !empty || (state_q != IDLE);
  assign bus.apb_psel     = psel_q;
  assign bus.apb_penable  = pen_q;
  assign bus.apb_pwrite   = pwrite_q;
  assign bus.apb_paddress = paddr_q;
  assign bus.apb_pwdata   = pwdata_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.rsp_rdata    = rsp_rdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master: a memory-backed slave with scripted
// wait states, a command-level reference model and decoupled monitors.
module tb_apb_cmd_master;
  import apb_cmd_pkg::*;

  localparam int AW = 8, DW = 8, DEPTH = 4, TO = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;

  apb_cmd_master_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

  apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .apb_pclk (clk),
    .resetn   (resetn),
    .bus      (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    cmd_t          c;
    int            dur;
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          exp_bus[$];
  exp_t          exp_rsp[$];
  int            waits[2048];
  logic [DW-1:0] mmem[256];
  logic [DW-1:0] smem[256];
  int            n_push = 0, s_idx = 0, s_cur = 0, s_acc = 0;
  int            total = 0, bad = 0;
  bit            mon_en = 1'b1;
  bit            cur_act = 1'b0;
  exp_t          cur;
  int            acc = 0;
  int            last_rsp_cyc = -1;
  int            last_accept_cyc = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Slave: ready on the (waits+1)-th ACCESS cycle of each transfer
  always @(negedge clk) begin
    if (ifc.apb_psel && !ifc.apb_penable) begin
      s_cur = s_idx;
      s_idx++;
      s_acc = 0;
      ifc.apb_pready = 1'($urandom);
      ifc.apb_prdata = 8'($urandom);
    end else if (ifc.apb_psel && ifc.apb_penable) begin
      if (s_acc == waits[s_cur]) begin
        ifc.apb_pready = 1'b1;
        ifc.apb_prdata = smem[ifc.apb_paddress];
        if (ifc.apb_pwrite) smem[ifc.apb_paddress] = ifc.apb_pwdata;
      end else begin
        ifc.apb_pready = 1'b0;
        ifc.apb_prdata = 8'($urandom);
      end
      s_acc++;
    end else begin
      ifc.apb_pready = 1'($urandom);
      ifc.apb_prdata = 8'($urandom);
    end
  end

  always @(negedge clk) begin
    if (mon_en && ifc.rsp_valid) begin
      exp_t e;
      last_rsp_cyc = cyc;
      if (exp_rsp.size() == 0) begin
        total++; bad++;
        $display("FAIL rsp_unexpected: got pulse expected none (cycle %0d)", cyc);
      end else begin
        e = exp_rsp.pop_front();
        chk("rsp_err", {31'd0, ifc.rsp_err}, {31'd0, e.err});
        chk("rsp_rdata", {24'd0, ifc.rsp_rdata}, {24'd0, e.rdata});
      end
    end
  end

  task automatic bus_final();
    chk("access_cycles", acc, cur.dur);
    cur_act = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ifc.apb_psel && !ifc.apb_penable) begin
        if (cur_act) bus_final();
        if (exp_bus.size() == 0) begin
          total++; bad++;
          $display("FAIL bus_setup_unexpected: got addr %0h expected no transfer", ifc.apb_paddress);
        end else begin
          cur = exp_bus.pop_front();
          cur_act = 1'b1;
          acc = 0;
          chk("setup_addr", {24'd0, ifc.apb_paddress}, {24'd0, cur.c.addr});
          chk("setup_write", {31'd0, ifc.apb_pwrite}, {31'd0, cur.c.write});
          if (cur.c.write) chk("setup_wdata", {24'd0, ifc.apb_pwdata}, {24'd0, cur.c.wdata});
        end
      end else if (ifc.apb_psel && ifc.apb_penable) begin
        if (!cur_act) begin
          total++; bad++;
          $display("FAIL bus_access_nosetup: got ACCESS expected SETUP first (cycle %0d)", cyc);
        end else begin
          acc++;
          chk("access_addr", {23'd0, ifc.apb_pwrite, ifc.apb_paddress},
              {23'd0, cur.c.write, cur.c.addr});
        end
      end else if (cur_act) begin
        bus_final();
      end
    end
  end

  task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d, output int waited);
    int   c;
    bit   rdy;
    exp_t e;
    waited = 0;
    @(negedge clk);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_write = w;
    ifc.cmd_addr  = a;
    ifc.cmd_wdata = d;
    forever begin
      rdy = ifc.cmd_ready;
      c   = cyc;
      @(posedge clk);
      if (rdy) break;
      waited++;
      if (waited > 200) begin
        total++; bad++;
        $display("FAIL push_wait: got no cmd_ready in %0d cycles expected accept", waited);
        #1 ifc.cmd_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    last_accept_cyc = c + 1;
    e.c.write = w; e.c.addr = a; e.c.wdata = d;
    if (waits[n_push] >= TO) begin
      e.dur = TO; e.err = 1'b1; e.rdata = '0;
    end else begin
      e.dur = waits[n_push] + 1; e.err = 1'b0;
      e.rdata = w ? 8'h00 : mmem[a];
      if (w) mmem[a] = d;
    end
    n_push++;
    exp_bus.push_back(e);
    exp_rsp.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int g = 0;
    @(negedge clk);
    while (ifc.busy && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk(nm, {31'd0, ifc.busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset(input string p);
    chk({p, "_cmd_ready"}, {31'd0, ifc.cmd_ready}, 32'd1);
    chk({p, "_rsp"}, {22'd0, ifc.rsp_valid, ifc.rsp_err, ifc.rsp_rdata}, 32'd0);
    chk({p, "_busy"}, {31'd0, ifc.busy}, 32'd0);
    chk({p, "_ctl"}, {29'd0, ifc.apb_psel, ifc.apb_penable, ifc.apb_pwrite}, 32'd0);
    chk({p, "_addr_data"}, {16'd0, ifc.apb_paddress, ifc.apb_pwdata}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wt, n1, ps_cyc, ps_rise, rsps, accs, a5, g;
    bit prev, seen;
    for (int i = 0; i < 256; i++) begin mmem[i] = '0; smem[i] = '0; end
    for (int i = 0; i < 2048; i++) begin
      int r = int'($urandom_range(0, 9));
      waits[i] = (r < 6) ? r % 4 : (r == 6) ? TO - 1 : (r == 7) ? TO : (r == 8) ? TO + 5 : 0;
    end
    ifc.cmd_valid = 1'b0; ifc.cmd_write = 1'b0; ifc.cmd_addr = '0; ifc.cmd_wdata = '0;
    ifc.apb_pready = 1'b0; ifc.apb_prdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    resetn = 1'b1;

    // Single zero-wait write
    waits[n_push] = 0;
    push(1'b1, 8'h00, 8'hEE, wt);
    n1 = last_accept_cyc;
    idle();
    chk("t1_n0_psel", {31'd0, ifc.apb_psel}, 32'd0);
    chk("t1_n0_busy", {31'd0, ifc.busy}, 32'd1);
    @(negedge clk);
    chk("t1_setup", {21'd0, ifc.apb_psel, ifc.apb_penable, ifc.apb_pwrite, ifc.apb_paddress},
        {21'd0, 3'b101, 8'h00});
    chk("t1_setup_wdata", {24'd0, ifc.apb_pwdata}, 32'hEE);
    @(negedge clk);
    chk("t1_access", {30'd0, ifc.apb_psel, ifc.apb_penable}, 32'd3);
    @(negedge clk);
    chk("t1_rsp", {22'd0, ifc.rsp_valid, ifc.rsp_err, ifc.rsp_rdata}, {22'd0, 2'b10, 8'h00});
    chk("t1_rsp_cycle", cyc, n1 + 3);
    chk("t1_psel_off", {31'd0, ifc.apb_psel}, 32'd0);
    wait_idle("t1_idle");

    // Back-to-back write then read
    waits[n_push] = 0; waits[n_push + 1] = 0;
    push(1'b1, 8'h01, 8'hCC, wt);
    push(1'b0, 8'h00, 8'h00, wt);
    idle();
    ps_cyc = 0; ps_rise = 0; rsps = 0; prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ifc.apb_psel) ps_cyc++;
      if (ifc.apb_psel && !prev) ps_rise++;
      if (ifc.rsp_valid) rsps++;
      prev = ifc.apb_psel;
      @(negedge clk);
    end
    chk("t2_psel_cycles", ps_cyc, 4);
    chk("t2_psel_bursts", ps_rise, 1);
    chk("t2_rsp_count", rsps, 2);

    // Read with three wait states
    waits[n_push] = 3;
    push(1'b0, 8'h01, 8'h00, wt);
    idle();
    accs = 0; rsps = 0;
    for (int i = 0; i < 20; i++) begin
      if (ifc.apb_psel && ifc.apb_penable) accs++;
      if (ifc.rsp_valid) rsps++;
      @(negedge clk);
    end
    chk("t3_access_len", accs, 4);
    chk("t3_rsp_count", rsps, 1);

    // Timeout followed by a queued write
    waits[n_push] = 1000; waits[n_push + 1] = 0;
    push(1'b0, 8'h02, 8'h00, wt);
    push(1'b1, 8'h03, 8'h5A, wt);
    idle();
    accs = 0; seen = 1'b0; g = 0;
    while (!seen && g < 60) begin
      if (ifc.rsp_valid) begin
        seen = 1'b1;
        chk("t4_timeout_len", accs, TO);
        chk("t4_next_setup", {30'd0, ifc.apb_psel, ifc.apb_penable}, 32'd2);
      end else if (ifc.apb_penable) accs++;
      @(negedge clk);
      g++;
    end
    chk("t4_rsp_seen", {31'd0, seen}, 32'd1);
    wait_idle("t4_idle");

    // FIFO full while the bus is stalled
    waits[n_push] = 1000;
    for (int i = 1; i <= 5; i++) waits[n_push + i] = i % 3;
    push(1'b0, 8'h05, 8'h00, wt);
    for (int i = 0; i < 4; i++) begin
      push(1'b1, 8'(8'h10 + i), 8'($urandom), wt);
      chk("t5_accept_nowait", wt, 0);
    end
    push(1'b0, 8'h11, 8'h00, wt);
    a5 = last_accept_cyc;
    idle();
    chk("t5_fifth_stalled", {31'd0, (wt > 0)}, 32'd1);
    chk("t5_ready_after_pop", a5, last_rsp_cyc + 1);
    wait_idle("t5_idle");

    // Reset during ACCESS with two reads queued
    waits[n_push] = 1000; waits[n_push + 1] = 0; waits[n_push + 2] = 0;
    push(1'b0, 8'h04, 8'h00, wt);
    push(1'b0, 8'h05, 8'h00, wt);
    push(1'b0, 8'h06, 8'h00, wt);
    idle();
    g = 0;
    while (!(ifc.apb_psel && ifc.apb_penable) && g < 20) begin @(negedge clk); g++; end
    chk("t6_in_access", {30'd0, ifc.apb_psel, ifc.apb_penable}, 32'd3);
    mon_en = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    check_reset("t6");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_rsp", {31'd0, ifc.rsp_valid}, 32'd0);
    end
    exp_bus.delete();
    exp_rsp.delete();
    cur_act = 1'b0;
    s_idx = n_push;
    resetn = 1'b1;
    mon_en = 1'b1;
    waits[n_push] = 0; waits[n_push + 1] = 1;
    push(1'b1, 8'h07, 8'h3C, wt);
    push(1'b0, 8'h07, 8'h00, wt);
    idle();
    wait_idle("t6_recover_idle");

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      push(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), wt);
      if ($urandom_range(0, 2) == 0) begin
        idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    idle();
    wait_idle("rand_idle");

    chk("drain_rsp", exp_rsp.size(), 0);
    chk("drain_bus", exp_bus.size() + int'(cur_act), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
